st7920_gdram_writer: RTL and testbench



---
 rtl/lcd12864_pkg.sv | 37 +++
 rtl/lcd_bus_slot.sv | 69 ++++++
 rtl/st7920_gdram_writer.sv | 217 +++++++++++++++++++++
 tb/tb_st7920_gdram_writer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd12864_pkg.sv
// Shared definitions for the ST7920 (LCD12864) GDRAM writer.
//   state_t      : controller FSM states
//   CMD_* / ADDR : ST7920 instruction bytes used by the writer
//   init_cmd()   : byte sent in each of the four init command slots
package lcd12864_pkg;

  typedef enum logic [3:0] {
    ST_PWR,    // power-on settle delay
    ST_INIT,   // four init command slots
    ST_CLRW,   // settle delay after display clear
    ST_GON,    // graphic display on
    ST_IDLE,   // waiting for a frame request
    ST_VADDR,  // vertical GDRAM address command
    ST_HADDR,  // horizontal GDRAM address command
    ST_DATA,   // one row of data bytes
    ST_FIN     // frame complete, done pulse
  } state_t;

  localparam logic [7:0] CMD_BASIC_8BIT = 8'h30;
  localparam logic [7:0] CMD_DISP_ON    = 8'h0C;
  localparam logic [7:0] CMD_CLEAR      = 8'h01;
  localparam logic [7:0] CMD_EXT        = 8'h34;
  localparam logic [7:0] CMD_GFX_ON     = 8'h36;
  localparam logic [7:0] ADDR_BASE      = 8'h80;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    case (idx)
      2'd0:    cmd = CMD_BASIC_8BIT;
      2'd1:    cmd = CMD_DISP_ON;
      2'd2:    cmd = CMD_CLEAR;
      default: cmd = CMD_EXT;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/lcd_bus_slot.sv
// One LCD parallel-bus transaction ("slot") of SLOT_CYC clocks.
//   clk, rst : clock, asynchronous active-high reset
//   go       : start a slot (accepted only while ready)
//   rs_in    : register-select for the slot, captured when go is accepted
//   dat_in   : bus byte, captured at slot cycle 1
//   ready    : slot can accept go (idle, or in its final cycle)
//   idle     : no slot in progress
//   lcd_rs, lcd_en, lcd_dat : LCD pins
module lcd_bus_slot #(
  parameter int SLOT_CYC = 32,
  parameter int EN_HI    = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic       rs_in,
  input  logic [7:0] dat_in,
  output logic       ready,
  output logic       idle,
  output logic       lcd_rs,
  output logic       lcd_en,
  output logic [7:0] lcd_dat
);

  localparam int CW = $clog2(SLOT_CYC);

  logic [CW-1:0] cnt_reg;
  logic          active_reg;
  logic [CW:0]   cnt_inc;
  logic          last_cyc;
  logic          en_next;

  assign last_cyc = (cnt_reg == CW'(SLOT_CYC - 1));
  assign ready    = !active_reg || last_cyc;
  assign idle     = !active_reg;
  assign cnt_inc  = {1'b0, cnt_reg} + 1'b1;
  // lcd_en is registered, so decide it from the cycle index about to start.
  assign en_next  = (cnt_inc >= (CW+1)'(2)) && (cnt_inc < (CW+1)'(2 + EN_HI));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg    <= '0;
      active_reg <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_en     <= 1'b0;
      lcd_dat    <= 8'h00;
    end else if (go && ready) begin
      // Back-to-back slots start right after the previous slot's last cycle.
      cnt_reg    <= '0;
      active_reg <= 1'b1;
      lcd_rs     <= rs_in;
      lcd_en     <= 1'b0;
    end else if (active_reg) begin
      if (last_cyc) begin
        active_reg <= 1'b0;
        lcd_en     <= 1'b0;
      end else begin
        cnt_reg <= cnt_inc[CW-1:0];
        lcd_en  <= en_next;
      end
      // The framebuffer answers one clock after the address (set at cycle 0),
      // so the bus byte is sampled during cycle 1, well ahead of lcd_en.
      if (cnt_reg == CW'(1)) begin
        lcd_dat <= dat_in;
      end
    end
  end

endmodule

// File: rtl/st7920_gdram_writer.sv
// ST7920 graphic-mode controller: runs the power-up init once per reset, then
// on each accepted start streams ROWS x WORDS x 2 bytes into GDRAM.
//   clk, rst     : clock, asynchronous active-high reset
//   start        : frame request, honoured only when idle
//   fill_en      : captured at start; 1 = send fill_byte, 0 = read framebuffer
//   fill_byte    : constant data for fill mode
//   busy, done   : handshake (done is a one-cycle pulse at frame end)
//   fb_addr      : framebuffer byte address; fb_data returns one clock later
//   lcd_rs, lcd_rw, lcd_en, lcd_dat : LCD parallel bus
module st7920_gdram_writer
  import lcd12864_pkg::*;
#(
  parameter int SLOT_CYC = 32,
  parameter int EN_HI    = 12,
  parameter int ROWS     = 32,
  parameter int WORDS    = 16,
  parameter int PWR_WAIT = 2000000,
  parameter int CLR_WAIT = 80000,
  parameter int AW       = $clog2(ROWS * WORDS * 2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          fill_en,
  input  logic [7:0]    fill_byte,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] fb_addr,
  input  logic [7:0]    fb_data,
  output logic          lcd_rs,
  output logic          lcd_rw,
  output logic          lcd_en,
  output logic [7:0]    lcd_dat
);

  localparam int BPR = 2 * WORDS;
  localparam int BW  = $clog2(BPR);
  localparam int YW  = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_t          state_reg, state_next;
  logic [31:0]     wait_reg;
  logic [1:0]      idx_reg;
  logic [YW-1:0]   y_reg;
  logic [BW-1:0]   b_reg;
  logic [AW-1:0]   ptr_reg;
  logic [AW-1:0]   fb_addr_reg;
  logic            fill_en_reg;
  logic [7:0]      fill_byte_reg;
  logic [7:0]      cmd_reg;
  logic            data_slot_reg;
  logic            init_done_reg;

  logic            go;
  logic            go_rs;
  logic [7:0]      go_cmd;
  logic            slot_ready;
  logic            slot_idle;
  logic [7:0]      slot_dat;
  logic            last_byte;
  logic            last_row;
  logic            start_ok;

  assign last_byte = (b_reg == BW'(BPR - 1));
  assign last_row  = (y_reg == YW'(ROWS - 1));
  assign start_ok  = start && init_done_reg;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_PWR;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_PWR:   if (wait_reg == 32'(PWR_WAIT - 1)) state_next = ST_INIT;
      ST_INIT: begin
        if (go) begin
          if (idx_reg == 2'd2)      state_next = ST_CLRW;
          else if (idx_reg == 2'd3) state_next = ST_GON;
        end
      end
      // The clear delay counts only once the clear slot has fully finished.
      ST_CLRW:  if (slot_idle && wait_reg == 32'(CLR_WAIT - 1)) state_next = ST_INIT;
      ST_GON:   if (go) state_next = ST_IDLE;
      ST_IDLE:  if (start_ok) state_next = ST_VADDR;
      ST_VADDR: if (go) state_next = ST_HADDR;
      ST_HADDR: if (go) state_next = ST_DATA;
      ST_DATA: begin
        if (go && last_byte) state_next = last_row ? ST_FIN : ST_VADDR;
      end
      ST_FIN:   if (slot_ready) state_next = ST_IDLE;
      default:  state_next = ST_PWR;
    endcase
  end

  // Output logic
  always_comb begin
    go     = 1'b0;
    go_rs  = 1'b0;
    go_cmd = 8'h00;
    busy   = 1'b1;
    done   = 1'b0;
    case (state_reg)
      ST_INIT: begin
        go     = slot_ready;
        go_cmd = init_cmd(idx_reg);
      end
      ST_GON: begin
        go     = slot_ready;
        go_cmd = CMD_GFX_ON;
      end
      ST_IDLE:  busy = 1'b0;
      ST_VADDR: begin
        go     = slot_ready;
        go_cmd = ADDR_BASE | 8'(y_reg);
      end
      ST_HADDR: begin
        go     = slot_ready;
        go_cmd = ADDR_BASE;
      end
      ST_DATA: begin
        go    = slot_ready;
        go_rs = 1'b1;
      end
      // done fires in the last cycle of the final data slot.
      ST_FIN: begin
        done = slot_ready;
        busy = !slot_ready;
      end
      default: ;
    endcase
  end

  // Counters and captured frame settings
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_reg      <= '0;
      idx_reg       <= '0;
      y_reg         <= '0;
      b_reg         <= '0;
      ptr_reg       <= '0;
      fb_addr_reg   <= '0;
      fill_en_reg   <= 1'b0;
      fill_byte_reg <= 8'h00;
      cmd_reg       <= 8'h00;
      data_slot_reg <= 1'b0;
      init_done_reg <= 1'b0;
    end else begin
      if (state_reg != state_next) begin
        wait_reg <= '0;
      end else if (state_reg == ST_PWR || (state_reg == ST_CLRW && slot_idle)) begin
        wait_reg <= wait_reg + 32'd1;
      end

      if (go) begin
        cmd_reg       <= go_cmd;
        data_slot_reg <= go_rs;
      end

      case (state_reg)
        ST_INIT: if (go) idx_reg <= idx_reg + 2'd1;
        ST_GON:  if (go) init_done_reg <= 1'b1;
        ST_IDLE: begin
          if (start_ok) begin
            fill_en_reg   <= fill_en;
            fill_byte_reg <= fill_byte;
            y_reg         <= '0;
            b_reg         <= '0;
            ptr_reg       <= '0;
          end
        end
        ST_DATA: begin
          if (go) begin
            // Rows are contiguous in the framebuffer, so a linear pointer
            // equals y*2*WORDS + b without a multiplier.
            fb_addr_reg <= ptr_reg;
            ptr_reg     <= ptr_reg + 1'b1;
            if (last_byte) begin
              b_reg <= '0;
              if (!last_row) y_reg <= y_reg + 1'b1;
            end else begin
              b_reg <= b_reg + 1'b1;
            end
          end
        end
        ST_FIN: if (slot_ready) y_reg <= '0;
        default: ;
      endcase
    end
  end

  assign slot_dat = data_slot_reg ? (fill_en_reg ? fill_byte_reg : fb_data) : cmd_reg;
  assign fb_addr  = fb_addr_reg;
  assign lcd_rw   = 1'b0;

  lcd_bus_slot #(
    .SLOT_CYC (SLOT_CYC),
    .EN_HI    (EN_HI)
  ) u_slot (
    .clk     (clk),
    .rst     (rst),
    .go      (go),
    .rs_in   (go_rs),
    .dat_in  (slot_dat),
    .ready   (slot_ready),
    .idle    (slot_idle),
    .lcd_rs  (lcd_rs),
    .lcd_en  (lcd_en),
    .lcd_dat (lcd_dat)
  );

endmodule

// File: tb/tb_st7920_gdram_writer.sv
module tb_st7920_gdram_writer;

  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          fill_en;
  logic [7:0]    fill_byte;
  logic          busy;
  logic          done;
  logic [AW-1:0] fb_addr;
  logic [7:0]    fb_data;
  logic          lcd_rs;
  logic          lcd_rw;
  logic          lcd_en;
  logic [7:0]    lcd_dat;

  st7920_gdram_writer #(
    .SLOT_CYC (8),
    .EN_HI    (3),
    .ROWS     (2),
    .WORDS    (2),
    .PWR_WAIT (20),
    .CLR_WAIT (10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .fill_en   (fill_en),
    .fill_byte (fill_byte),
    .busy      (busy),
    .done      (done),
    .fb_addr   (fb_addr),
    .fb_data   (fb_data),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_en    (lcd_en),
    .lcd_dat   (lcd_dat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rs;
    logic [7:0] dat;
  } slot_t;

  typedef struct {
    bit          fill;
    logic [7:0]  fill_byte;
    logic [7:0]  fb_base;
    logic [63:0] exp_data;   // byte i = expected data byte i of the frame
    bit          extra;      // second start in the middle of the frame
    bit          sad;        // start raised in the done cycle
  } frame_vec_t;

  int         checks = 0;
  int         fails  = 0;
  logic [7:0] fb_mem [8];
  slot_t      slot_q [$];
  int         gap_q  [$];
  slot_t      init_tab [5];
  frame_vec_t vecs [5];

  // monitor state
  logic       prev_en;
  logic       hold_rs;
  logic [7:0] hold_dat;
  int         hi_cnt, cyc, last_fall, done_cnt, fb_max;

  // Framebuffer with one-clock registered read
  always @(posedge clk) fb_data <= fb_mem[fb_addr];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic chk_range(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, got, lo, hi);
    end
  endtask

  // Bus monitor: records each enable pulse as the slot the LCD latched
  always @(negedge clk) begin
    if (rst) begin
      prev_en   = 1'b0;
      cyc       = 0;
      last_fall = 0;
      hi_cnt    = 0;
    end else begin
      cyc++;
      if (done === 1'b1) done_cnt++;
      if (int'(fb_addr) > fb_max) fb_max = int'(fb_addr);
      if (lcd_en === 1'b1 && !prev_en) begin
        hold_rs  = lcd_rs;
        hold_dat = lcd_dat;
        hi_cnt   = 1;
        gap_q.push_back(cyc - last_fall);
        checks++;
        if (lcd_rw !== 1'b0) begin
          fails++;
          $display("FAIL lcd_rw: got %0b, required 0", lcd_rw);
        end
      end else if (lcd_en === 1'b1) begin
        hi_cnt++;
        checks++;
        if (lcd_rs !== hold_rs || lcd_dat !== hold_dat) begin
          fails++;
          $display("FAIL bus_stable: rs/dat %0b/%02h, required %0b/%02h",
                   lcd_rs, lcd_dat, hold_rs, hold_dat);
        end
      end else if (prev_en) begin
        checks++;
        if (hi_cnt != 3) begin
          fails++;
          $display("FAIL en_width: high %0d cycles, required 3", hi_cnt);
        end
        slot_q.push_back({hold_rs, hold_dat});
        last_fall = cyc;
      end
      prev_en = (lcd_en === 1'b1);
    end
  end

  task automatic check_init(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    repeat (12) @(negedge clk);
    chk({tag, "_slot_count"}, slot_q.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < slot_q.size()) chk($sformatf("%s_cmd%0d", tag, i), 32'(slot_q[i]), 32'(init_tab[i]));
    end
    if (gap_q.size() >= 5) begin
      chk_range({tag, "_pwr_delay"}, gap_q[0], 21, 28);
      chk({tag, "_gap1"}, gap_q[1], 32'd5);
      chk({tag, "_gap2"}, gap_q[2], 32'd5);
      chk_range({tag, "_clr_delay"}, gap_q[3], 13, 20);
      chk({tag, "_gap4"}, gap_q[4], 32'd5);
    end
    chk({tag, "_no_done"}, done_cnt, 32'd0);
    $display("init %s: %0d command slots seen", tag, slot_q.size());
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  initial begin
    slot_t    exp_s;
    bit       got_done;
    int       n;
    int       r, k;
    logic [63:0] ed;

    init_tab[0] = {1'b0, 8'h30};
    init_tab[1] = {1'b0, 8'h0C};
    init_tab[2] = {1'b0, 8'h01};
    init_tab[3] = {1'b0, 8'h34};
    init_tab[4] = {1'b0, 8'h36};

    vecs[0] = '{1'b0, 8'h00, 8'h00, 64'h0706050403020100, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'hAA, 8'h10, 64'hAAAAAAAAAAAAAAAA, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'h33, 8'h40, 64'h4746454443424140, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'h5C, 8'h20, 64'h5C5C5C5C5C5C5C5C, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 8'h00, 8'hF8, 64'hFFFEFDFCFBFAF9F8, 1'b0, 1'b0};

    for (int i = 0; i < 8; i++) fb_mem[i] = 8'(i);
    rst = 1'b1; start = 1'b0; fill_en = 1'b0; fill_byte = 8'h00;
    done_cnt = 0; fb_max = 0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_lcd_rs", 32'(lcd_rs), 32'd0);
    chk("rst_lcd_rw", 32'(lcd_rw), 32'd0);
    chk("rst_lcd_en", 32'(lcd_en), 32'd0);
    chk("rst_lcd_dat", 32'(lcd_dat), 32'h00);
    chk("rst_fb_addr", 32'(fb_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_done", 32'(done), 32'd0);

    @(posedge clk);
    #1 rst = 1'b0;
    // A start during the power-up wait must be ignored, not queued
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check_init("init1");
    repeat (20) @(negedge clk);
    chk("no_queued_start_busy", 32'(busy), 32'd0);
    chk("no_queued_start_slots", slot_q.size(), 32'd5);

    // Frame table
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 8; i++) fb_mem[i] = vecs[f].fb_base + 8'(i);
      slot_q.delete();
      done_cnt  = 0;
      fb_max    = 0;
      fill_en   = vecs[f].fill;
      fill_byte = vecs[f].fill_byte;
      pulse_start();
      // Settings are captured at start; scramble the live inputs afterwards
      fill_en   = ~vecs[f].fill;
      fill_byte = ~vecs[f].fill_byte;
      @(negedge clk);
      chk($sformatf("f%0d_busy_rise", f), 32'(busy), 32'd1);

      got_done = 1'b0;
      n = 0;
      while (n < 400 && !got_done) begin
        @(negedge clk);
        n++;
        if (vecs[f].extra && n == 30) start = 1'b1;
        if (n == 31) start = 1'b0;
        if (done === 1'b1) got_done = 1'b1;
      end
      chk($sformatf("f%0d_done_seen", f), 32'(got_done), 32'd1);
      if (vecs[f].sad && got_done) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (20) @(negedge clk);

      chk($sformatf("f%0d_busy_after", f), 32'(busy), 32'd0);
      chk($sformatf("f%0d_done_count", f), done_cnt, 32'd1);
      chk($sformatf("f%0d_fb_addr_max", f), fb_max, 32'd7);
      chk($sformatf("f%0d_slot_count", f), slot_q.size(), 32'd12);
      ed = vecs[f].exp_data;
      for (int i = 0; i < 12; i++) begin
        r = i / 6;
        k = i % 6;
        if (k == 0)      exp_s = {1'b0, 8'h80 | 8'(r)};
        else if (k == 1) exp_s = {1'b0, 8'h80};
        else             exp_s = {1'b1, ed[8*(r*4 + k - 2) +: 8]};
        if (i < slot_q.size()) chk($sformatf("f%0d_slot%0d", f, i), 32'(slot_q[i]), 32'(exp_s));
      end
      $display("frame %0d: fill=%0b slots=%0d done=%0d fb_max=%0d", f, vecs[f].fill,
               slot_q.size(), done_cnt, fb_max);
    end

    // Reset in the middle of the data phase
    for (int i = 0; i < 8; i++) fb_mem[i] = 8'(i);
    fill_en = 1'b0;
    pulse_start();
    n = 0;
    while (!(lcd_rs === 1'b1 && lcd_en === 1'b1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("mid_data_reached", 32'(lcd_rs & lcd_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_en", 32'(lcd_en), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd1);
    chk("async_rst_rs", 32'(lcd_rs), 32'd0);
    chk("async_rst_fb_addr", 32'(fb_addr), 32'd0);
    $display("reset mid-data applied");
    repeat (3) @(negedge clk);
    slot_q.delete();
    gap_q.delete();
    done_cnt = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    check_init("init2");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
